voice_mixer: RTL
================

Name: voice_mixer

Overview:
- Four-input gain/mix stage that sits directly upstream of i2s_tx.
- Consumes per-frame samples from the sine, multiplier, echo and mic paths, applies a per-channel unsigned gain and an enable mask, and sums the channels.
- Saturates the sum to BITSIZE and presents one registered mixed sample per DACLRC frame, so the top level can drive left_chan/right_chan from a single mixed source.
- Uses one time-multiplexed multiply-accumulate, so only one multiplier is inferred.

Parameters:
BITSIZE, 16, sample width (signed two's complement) of all audio inputs and the output
GAINBITS, 8, width of each unsigned gain word; unity gain = 2**(GAINBITS-1)

Ports:
bclk  input  1  bit clock, sole clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
lrclk  input  1  DACLRC frame clock, sampled as data in the bclk domain
in0..in3  input  BITSIZE each  signed channel samples, sampled only at frame start
gain0..gain3  input  GAINBITS each  unsigned channel gains, sampled only at frame start
enable_mask  input  4  bit i = 1 includes channel i; a 0 forces that channel's contribution to 0
out  output  BITSIZE  signed mixed, saturated sample
out_valid  output  1  one-cycle pulse when out updates
clip  output  1  1 if the last published sample saturated; held until the next publish

Behaviour:
- Reset (async assert, sync to bclk on release): out=0, out_valid=0, clip=0, lrclk_d=0, state=IDLE, idx=0, acc=0, sample/gain latches=0.
- Frame start: lrclk_d registers lrclk each posedge. A rising edge is lrclk=1 & lrclk_d=0 at posedge k.
- At posedge k, regardless of state:
  - latch in0..3, gain0..3 and enable_mask into internal registers;
  - clear acc and idx=0;
  - enter MAC.
  - An edge arriving while in MAC or SAT abandons the current computation without publishing (restart). out keeps its previous value.
- MAC: posedges k+1..k+4 process channel idx=0..3, one channel per cycle.
  - Per channel: acc += mask[idx] ? sext(in_idx) * zext(gain_idx) : 0.
  - Product width is BITSIZE+GAINBITS+1 signed; acc width is BITSIZE+GAINBITS+2 signed, so no overflow is possible.
  - After idx=3, go to SAT.
- SAT: posedge k+5 computes s = acc >>> (GAINBITS-1) (arithmetic, floor toward -inf, no rounding).
  - If s > 2**(BITSIZE-1)-1: out=max, clip=1.
  - If s < -2**(BITSIZE-1): out=min, clip=1.
  - Otherwise: out=s[BITSIZE-1:0], clip=0.
  - Also at k+5: out_valid=1, then return to IDLE.
- Latency: out/clip/out_valid are visible after posedge k+5, i.e. 5 bclk after the detecting posedge. out_valid is high for exactly that one cycle.
- IDLE: out, clip held; out_valid=0. Inputs changing outside the frame-start posedge have no effect.
- Falling lrclk edges are ignored.
- lrclk held constant: no further publishes; out held indefinitely.
- Reset asserted mid-MAC: immediate return to reset values; no publish. The first publish after release requires a fresh rising edge.
- Gain=0 or mask=0 for all channels: out=0, clip=0, out_valid still pulses.
- Minimum frame spacing for a publish: 6 bclk between rising edges. The I2S frame (≥32 bclk) always satisfies this.

Test Plan:
- Reset then lrclk rise with in0=1000, gain0=128, others 0, mask=4'b1111 → 5 bclk later out=1000, clip=0, out_valid pulses 1 cycle.
- in0=in1=20000, gain0=gain1=128, mask=4'b0011 → out=32767, clip=1. Repeat with -20000 → out=-32768, clip=1.
- Scaling/floor: in0=1001, gain0=64 → out=500. in0=-1001, gain0=64 → out=-501. in0=100, gain0=255 → out=199.
- Mask: in0..3=1000, gains=128, mask=4'b0101 → out=2000. Change in0 mid-MAC to 5000 → out still 2000.
- Restart: second lrclk rise 3 bclk after the first, with in0=7 and gain0=128 → only one out_valid pulse, 5 bclk after the second edge, out=7.
- Reset asserted at k+3 → out=0, no out_valid. After release with no new edge, out stays 0 for 40 bclk. Next edge publishes normally.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer: four-channel gain/mix stage ahead of the I2S transmitter.
// One shared multiply-accumulate walks the channels after each frame start.
module voice_mixer #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
) (
    input  logic                bclk,
    input  logic                reset_n,
    input  logic                lrclk,
    input  logic [BITSIZE-1:0]  in0,
    input  logic [BITSIZE-1:0]  in1,
    input  logic [BITSIZE-1:0]  in2,
    input  logic [BITSIZE-1:0]  in3,
    input  logic [GAINBITS-1:0] gain0,
    input  logic [GAINBITS-1:0] gain1,
    input  logic [GAINBITS-1:0] gain2,
    input  logic [GAINBITS-1:0] gain3,
    input  logic [3:0]          enable_mask,
    output logic [BITSIZE-1:0]  out,
    output logic                out_valid,
    output logic                clip
);

    localparam int PW = BITSIZE + GAINBITS + 1;
    localparam int AW = PW + 1;
    localparam logic signed [AW-1:0] SMAX = AW'(2**(BITSIZE-1) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(2**(BITSIZE-1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } state_t;

    state_t                    state_q, state_d;
    logic                      lrclk_q, lrclk_d;
    logic [1:0]                idx_q, idx_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic [BITSIZE-1:0]        in_q [4];
    logic [BITSIZE-1:0]        in_d [4];
    logic [GAINBITS-1:0]       gain_q [4];
    logic [GAINBITS-1:0]       gain_d [4];
    logic [3:0]                mask_q, mask_d;
    logic [BITSIZE-1:0]        out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      clip_q, clip_d;

    logic                      rise;
    logic signed [PW-1:0]      op_a, op_b, prod;
    logic signed [AW-1:0]      mac_term;
    logic signed [AW-1:0]      scaled;

    assign rise     = lrclk & ~lrclk_q;
    assign op_a     = PW'($signed(in_q[idx_q]));
    assign op_b     = PW'({1'b0, gain_q[idx_q]});
    assign prod     = op_a * op_b;
    assign mac_term = mask_q[idx_q] ? AW'(prod) : '0;
    assign scaled   = acc_q >>> (GAINBITS - 1);

    // Next-state: frame-start latch/restart, channel MAC walk, saturate and publish
    always_comb begin
        state_d     = state_q;
        lrclk_d     = lrclk;
        idx_d       = idx_q;
        acc_d       = acc_q;
        in_d        = in_q;
        gain_d      = gain_q;
        mask_d      = mask_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        clip_d      = clip_q;
        if (rise) begin
            in_d[0]   = in0;
            in_d[1]   = in1;
            in_d[2]   = in2;
            in_d[3]   = in3;
            gain_d[0] = gain0;
            gain_d[1] = gain1;
            gain_d[2] = gain2;
            gain_d[3] = gain3;
            mask_d    = enable_mask;
            acc_d     = '0;
            idx_d     = 2'd0;
            state_d   = MAC;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                MAC: begin
                    acc_d = acc_q + mac_term;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = SAT;
                    end
                end
                SAT: begin
                    unique case (1'b1)
                        (scaled > SMAX): begin
                            out_d  = SMAX[BITSIZE-1:0];
                            clip_d = 1'b1;
                        end
                        (scaled < SMIN): begin
                            out_d  = SMIN[BITSIZE-1:0];
                            clip_d = 1'b1;
                        end
                        default: begin
                            out_d  = scaled[BITSIZE-1:0];
                            clip_d = 1'b0;
                        end
                    endcase
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lrclk_q     <= 1'b0;
            idx_q       <= 2'd0;
            acc_q       <= '0;
            in_q        <= '{default: '0};
            gain_q      <= '{default: '0};
            mask_q      <= 4'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrclk_q     <= lrclk_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_q        <= in_d;
            gain_q      <= gain_d;
            mask_q      <= mask_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;

endmodule
